wb_regfile: RTL and testbench

//   Writeback stage and GPR file; consumes the M->W pipeline register outputs.

---
 rtl/wb_regfile_if.sv | 37 +++
 rtl/wb_regfile.sv | 161 ++++++++++++++++
 tb/tb_wb_regfile.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Writeback-stage bus: M->W pipeline register outputs, D-stage read ports,
// and the values the writeback stage exports (forwarding data, write strobe,
// retired-instruction count).
interface wb_regfile_if;

    // M->W pipeline register outputs
    logic [2:0]  res_w;
    logic [4:0]  a3_w;
    logic [31:0] instr_w;
    logic [31:0] ao_w;
    logic [31:0] dr_w;
    logic [31:0] pc8_w;

    // D-stage read ports
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    // Writeback results
    logic [31:0] wd_w;
    logic        we_w;
    logic [31:0] instret;

    // Upstream pipeline / decode side
    modport master (
        output res_w, a3_w, instr_w, ao_w, dr_w, pc8_w, ra1, ra2,
        input  rd1, rd2, wd_w, we_w, instret
    );

    // Writeback stage and register file
    modport slave (
        input  res_w, a3_w, instr_w, ao_w, dr_w, pc8_w, ra1, ra2,
        output rd1, rd2, wd_w, we_w, instret
    );

endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 GPR file.
// Selects the writeback value (ALU result, extended load data or PC+8),
// writes it into the register file, serves two read ports with same-cycle
// write bypass, and counts retired (non-bubble) instructions.
// Optional build macro: WB_TRACE_EN prints every committed write (and any
// attempted write to $0) at the clock edge; datapath is identical either way.
module wb_regfile (
    input  logic          clk,
    input  logic          reset,
    wb_regfile_if.slave   bus
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned AW     = 5;

    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_PC  = 3'd3;

    localparam logic [5:0] OP_LB   = 6'h20;
    localparam logic [5:0] OP_LH   = 6'h21;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_LBU  = 6'h24;
    localparam logic [5:0] OP_LHU  = 6'h25;

    logic [XLEN-1:0] gpr_q [NREG];
    logic [XLEN-1:0] gpr_d [NREG];
    logic [XLEN-1:0] instret_q;
    logic [XLEN-1:0] instret_d;

    logic [5:0]      opcode;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] wd;
    logic            res_valid;
    logic            we;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    assign opcode = bus.instr_w[31:26];

    // Pick the addressed byte and halfword out of the raw memory word
    always_comb begin
        ld_byte = bus.dr_w[7:0];
        unique case (bus.ao_w[1:0])
            2'd0: ld_byte = bus.dr_w[7:0];
            2'd1: ld_byte = bus.dr_w[15:8];
            2'd2: ld_byte = bus.dr_w[23:16];
            2'd3: ld_byte = bus.dr_w[31:24];
            default: ld_byte = bus.dr_w[7:0];
        endcase
        ld_half = bus.ao_w[1] ? bus.dr_w[31:16] : bus.dr_w[15:0];
    end

    // Load extension by opcode; unknown opcodes pass the word through
    always_comb begin
        ld_ext = bus.dr_w;
        unique case (opcode)
            OP_LW:   ld_ext = bus.dr_w;
            OP_LB:   ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
            OP_LH:   ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            OP_LHU:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_ext = bus.dr_w;
        endcase
    end

    // Writeback source select; unused res codes produce zero and no write
    always_comb begin
        wd        = '0;
        res_valid = 1'b0;
        unique case (bus.res_w)
            RES_ALU: begin
                wd        = bus.ao_w;
                res_valid = 1'b1;
            end
            RES_DM: begin
                wd        = ld_ext;
                res_valid = 1'b1;
            end
            RES_PC: begin
                wd        = bus.pc8_w;
                res_valid = 1'b1;
            end
            default: begin
                wd        = '0;
                res_valid = 1'b0;
            end
        endcase
        we = res_valid && (bus.a3_w != AW'(0));
    end

    // Next register-file contents; $0 is never a write target
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        if (we) begin
            gpr_d[bus.a3_w] = wd;
        end
        gpr_d[0] = '0;
    end

    // Retired-instruction count; all-zero instructions are bubbles
    always_comb begin
        instret_d = instret_q;
        if (bus.instr_w != '0) begin
            instret_d = instret_q + XLEN'(1);
        end
    end

    // Register file and counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
            instret_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            instret_q <= instret_d;
        end
    end

    // Read ports: $0 reads zero, a same-cycle write to the address bypasses
    always_comb begin
        rd1 = gpr_q[bus.ra1];
        if (bus.ra1 == AW'(0)) begin
            rd1 = '0;
        end else if (we && (bus.ra1 == bus.a3_w)) begin
            rd1 = wd;
        end
        rd2 = gpr_q[bus.ra2];
        if (bus.ra2 == AW'(0)) begin
            rd2 = '0;
        end else if (we && (bus.ra2 == bus.a3_w)) begin
            rd2 = wd;
        end
    end

    assign bus.rd1     = rd1;
    assign bus.rd2     = rd2;
    assign bus.wd_w    = wd;
    assign bus.we_w    = we;
    assign bus.instret = instret_q;

`ifdef WB_TRACE_EN
    // Commit trace, including attempted writes to $0
    always @(posedge clk) begin
        if (!reset && (we || ((bus.a3_w == AW'(0)) && (bus.res_w != 3'd0)))) begin
            $display("@%h: $%d <= %h", bus.pc8_w - XLEN'(8), bus.a3_w, wd);
        end
    end
`else
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, bypass, load extension, link writes,
// $0 handling, invalid res codes and the retired-instruction counter.
module tb_wb_regfile;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] res, input logic [4:0] a3, input logic [31:0] instr,
                         input logic [31:0] ao, input logic [31:0] dr, input logic [31:0] pc8);
        bus.res_w   = res;
        bus.a3_w    = a3;
        bus.instr_w = instr;
        bus.ao_w    = ao;
        bus.dr_w    = dr;
        bus.pc8_w   = pc8;
    endtask

    // Commit on the next rising edge and return to the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.ra1 = 5'd5;
        bus.ra2 = 5'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_instret", bus.instret, 32'h0);
        check("reset_rd1", bus.rd1, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Async reset mid-run wipes $5 and instret without a clock edge
        drive(3'd1, 5'd5, 32'h0000_0001, 32'h0000_1234, 32'h0, 32'h0);
        step();
        drive(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.ra1 = 5'd5;
        #1;
        check("pre_reset_r5", bus.rd1, 32'h0000_1234);
        check("pre_reset_instret", bus.instret, 32'h1);
        reset = 1'b1;
        #1;
        check("async_reset_r5", bus.rd1, 32'h0);
        check("async_reset_instret", bus.instret, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Same-cycle bypass on both ports, then stored value
        drive(3'd1, 5'd8, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0, 32'h0);
        bus.ra1 = 5'd8;
        bus.ra2 = 5'd8;
        #1;
        check("bypass_rd1", bus.rd1, 32'hDEAD_BEEF);
        check("bypass_rd2", bus.rd2, 32'hDEAD_BEEF);
        check("bypass_we", 32'(bus.we_w), 32'h1);
        step();
        drive(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        check("stored_r8", bus.rd1, 32'hDEAD_BEEF);

        // Load extension
        drive(3'd2, 5'd10, {6'h20, 26'h0}, 32'h0000_0002, 32'h1280_FF7F, 32'h0);
        #1;
        check("lb_off2", bus.wd_w, 32'hFFFF_FF80);
        drive(3'd2, 5'd10, {6'h24, 26'h0}, 32'h0000_0002, 32'h1280_FF7F, 32'h0);
        #1;
        check("lbu_off2", bus.wd_w, 32'h0000_0080);
        drive(3'd2, 5'd10, {6'h20, 26'h0}, 32'h0000_0000, 32'h1280_FF7F, 32'h0);
        #1;
        check("lb_off0", bus.wd_w, 32'h0000_007F);
        drive(3'd2, 5'd10, {6'h20, 26'h0}, 32'h0000_0003, 32'h1280_FF7F, 32'h0);
        #1;
        check("lb_off3", bus.wd_w, 32'h0000_0012);
        drive(3'd2, 5'd10, {6'h21, 26'h0}, 32'h0000_0000, 32'h1280_FF7F, 32'h0);
        #1;
        check("lh_lo", bus.wd_w, 32'hFFFF_FF7F);
        drive(3'd2, 5'd10, {6'h25, 26'h0}, 32'h0000_0000, 32'h1280_FF7F, 32'h0);
        #1;
        check("lhu_lo", bus.wd_w, 32'h0000_FF7F);
        drive(3'd2, 5'd10, {6'h23, 26'h0}, 32'h0000_0002, 32'h1280_FF7F, 32'h0);
        #1;
        check("lw", bus.wd_w, 32'h1280_FF7F);
        drive(3'd2, 5'd10, {6'h21, 26'h0}, 32'h0000_0002, 32'h1280_FF7F, 32'h0);
        #1;
        check("lh_hi", bus.wd_w, 32'h0000_1280);
        step();
        drive(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.ra1 = 5'd10;
        #1;
        check("stored_r10", bus.rd1, 32'h0000_1280);

        // Link write to $31, then a write aimed at $0
        drive(3'd3, 5'd31, 32'h0000_0001, 32'h0, 32'h0, 32'h0000_3008);
        step();
        drive(3'd1, 5'd0, 32'h0000_0001, 32'h0000_0005, 32'h0, 32'h0);
        bus.ra1 = 5'd31;
        bus.ra2 = 5'd0;
        #1;
        check("stored_r31", bus.rd1, 32'h0000_3008);
        check("r0_we", 32'(bus.we_w), 32'h0);
        check("r0_rd2_bypass", bus.rd2, 32'h0);
        step();
        drive(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        check("r0_after", bus.rd2, 32'h0);

        // Invalid res codes neither write nor produce data
        drive(3'd1, 5'd9, 32'h0000_0001, 32'h0000_0099, 32'h0, 32'h0);
        step();
        drive(3'd0, 5'd9, 32'h0000_0001, 32'h0000_0077, 32'h0, 32'h0);
        bus.ra1 = 5'd9;
        #1;
        check("res0_we", 32'(bus.we_w), 32'h0);
        check("res0_wd", bus.wd_w, 32'h0);
        check("res0_no_bypass", bus.rd1, 32'h0000_0099);
        step();
        drive(3'd5, 5'd9, 32'h0000_0001, 32'h0000_0077, 32'h0, 32'h0);
        #1;
        check("res5_we", 32'(bus.we_w), 32'h0);
        check("res5_wd", bus.wd_w, 32'h0);
        step();
        drive(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        check("r9_unchanged", bus.rd1, 32'h0000_0099);

        // Counter: ten instructions and three bubbles after a fresh reset
        reset = 1'b1;
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            if (i == 3 || i == 7 || i == 11) begin
                drive(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
            end else begin
                drive(3'd0, 5'd0, 32'(i + 1), 32'h0, 32'h0, 32'h0);
            end
            step();
        end
        drive(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        check("instret_10", bus.instret, 32'd10);

        // Counter wrap
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        check("instret_max", bus.instret, 32'hFFFF_FFFF);
        drive(3'd0, 5'd0, 32'h0000_0001, 32'h0, 32'h0, 32'h0);
        step();
        drive(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        check("instret_wrap", bus.instret, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
